// File: rtl/mlaccel_pkg.sv
// Shared definitions for the accelerator QSPI master: FSM encoding,
// pad output-enable patterns and clock divider limits.
package mlaccel_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   localparam logic [3:0] OE_NONE    = 4'b0000;
   localparam logic [3:0] OE_SINGLE  = 4'b0001;
   localparam logic [3:0] OE_QUAD_WR = 4'b1111;
   localparam logic [3:0] OE_QUAD_RD = 4'b0000;

   localparam int CLKDIV_MIN = 1;
   localparam int CLKDIV_MAX = 255;

   function automatic logic [3:0] oe_pattern(input logic quad, input logic dir);
      if (!quad) return OE_SINGLE;
      return dir ? OE_QUAD_RD : OE_QUAD_WR;
   endfunction

endpackage

// File: rtl/mlaccel_sync2.sv
// Two-flop synchronizer for asynchronous single-bit accelerator status lines.
module mlaccel_sync2 (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mlaccel_qspi_master.sv
// Byte-oriented single/quad SPI master (mode 0) for the ML accelerator link.
// Handshake: a transfer moves on cmd_* or rsp_* only in a cycle where valid and ready are both high.
module mlaccel_qspi_master
   import mlaccel_pkg::*;
#(
   parameter int CLKDIV = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_byte,
   input  logic       cmd_dir,
   input  logic       cmd_quad,
   input  logic       cmd_last,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   input  logic       rsp_ready,
   output logic       ml_clk,
   output logic       ml_csb,
   output logic [3:0] io_oe,
   output logic [3:0] io_do,
   input  logic [3:0] io_di,
   input  logic       ml_irq,
   input  logic       ml_err,
   output logic       busy,
   output logic       irq_sync,
   output logic       err_flag,
   input  logic       err_clr
);

   localparam int DIV = (CLKDIV < CLKDIV_MIN) ? CLKDIV_MIN :
                        ((CLKDIV > CLKDIV_MAX) ? CLKDIV_MAX : CLKDIV);
   localparam logic [8:0] LIM_PHASE = 9'(DIV - 1);
   localparam logic [8:0] LIM_GAP   = 9'(2 * DIV - 1);

   state_t     state, state_nxt;
   logic [8:0] cnt;
   logic [4:0] phase;
   logic       cur_dir, cur_quad, cur_last;
   logic [7:0] tx, rx;
   logic       accept, tick, last_phase, shift_end;
   logic       err_s, err_s_d;

   assign accept     = cmd_valid && cmd_ready;
   assign tick       = (cnt == LIM_PHASE);
   assign last_phase = (phase == (cur_quad ? 5'd3 : 5'd15));
   assign shift_end  = (state == ST_SHIFT) && tick && last_phase;

   always_ff @(posedge clk) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_SETUP;
         ST_SETUP: if (tick) state_nxt = ST_SHIFT;
         ST_SHIFT: if (shift_end) state_nxt = cur_last ? ST_HOLD : ST_WAIT;
         ST_WAIT:  if (accept) state_nxt = ST_SHIFT;
         ST_HOLD:  if (tick) state_nxt = ST_GAP;
         ST_GAP:   if (cnt == LIM_GAP) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ml_csb    = (state == ST_IDLE) || (state == ST_GAP);
      busy      = (state != ST_IDLE);
      cmd_ready = resetn && ((state == ST_IDLE) || (state == ST_WAIT)) &&
                  (!rsp_valid || rsp_ready);
   end

   // Reads park io0 low; writes present the MSB (or top nibble) of the shifter.
   assign io_do = cur_dir  ? 4'b0000 :
                  cur_quad ? tx[7:4] : {3'b000, tx[7]};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt       <= '0;
         phase     <= '0;
         ml_clk    <= 1'b0;
         io_oe     <= OE_NONE;
         tx        <= '0;
         rx        <= '0;
         cur_dir   <= 1'b0;
         cur_quad  <= 1'b0;
         cur_last  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         if (state != state_nxt || state == ST_IDLE || state == ST_WAIT ||
             (state == ST_SHIFT && tick))
            cnt <= '0;
         else
            cnt <= cnt + 9'd1;

         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

         if (accept) begin
            cur_dir  <= cmd_dir;
            cur_quad <= cmd_quad;
            cur_last <= cmd_last;
            tx       <= cmd_dir ? 8'h00 : cmd_byte;
            rx       <= '0;
            io_oe    <= oe_pattern(cmd_quad, cmd_dir);
            phase    <= '0;
            ml_clk   <= 1'b0;
         end

         if (state == ST_SHIFT && tick) begin
            ml_clk <= ~ml_clk;
            phase  <= phase + 5'd1;
            // Rising edge captures input; falling edge advances output for the next bit.
            if (!ml_clk)
               rx <= cur_quad ? {rx[3:0], io_di} : {rx[6:0], io_di[1]};
            else if (!last_phase)
               tx <= cur_quad ? {tx[3:0], 4'h0} : {tx[6:0], 1'b0};
         end

         if (shift_end && cur_dir) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rx;
         end

         if (state == ST_HOLD && tick) io_oe <= OE_NONE;
      end
   end

   mlaccel_sync2 u_sync_irq (.clk(clk), .resetn(resetn), .d(ml_irq), .q(irq_sync));
   mlaccel_sync2 u_sync_err (.clk(clk), .resetn(resetn), .d(ml_err), .q(err_s));

   // A fresh error edge outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         err_s_d  <= 1'b0;
         err_flag <= 1'b0;
      end else begin
         err_s_d <= err_s;
         if (err_s && !err_s_d) err_flag <= 1'b1;
         else if (err_clr)      err_flag <= 1'b0;
      end
   end

endmodule
